// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

    typedef enum logic [0:0] {
        IDLE,
        SHIFT
    } piso_state_t;

    // Bit-index width; a 2-bit word still needs one index bit.
    function automatic int unsigned idx_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry holding register that parks the next word while the current one shifts.
module piso_hold_buf #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] data_i,
    input  logic             take_i,
    output logic [Width-1:0] data_o,
    output logic             full_o
);

    logic [Width-1:0] data_q, data_d;
    logic             full_q, full_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (load_i) begin
            data_d = data_i;
            full_d = 1'b1;
        end else if (take_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/piso_serializer.sv
// Parametrised PISO serializer: valid/ready load, one-word holding buffer for
// gap-free streaming, bit-rate enable, selectable bit order and framing flags.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);

    localparam int unsigned     IdxW    = idx_width(WIDTH);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

    piso_state_t      state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             ser_q, ser_d;
    logic [IdxW-1:0]  pos;

    logic             accept;
    logic             hload, htake, hfull;
    logic [WIDTH-1:0] hdata;

    assign load_ready = !hfull && !rst;
    assign accept     = load_valid && load_ready;

    piso_hold_buf #(
        .Width(WIDTH)
    ) u_hold_buf (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (hload),
        .data_i (load_data),
        .take_i (htake),
        .data_o (hdata),
        .full_o (hfull)
    );

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        idx_d   = idx_q;
        hload   = 1'b0;
        htake   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sreg_d  = load_data;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en && (idx_q == LastIdx)) begin
                    // Word boundary: buffered word first, then a same-edge bypass.
                    idx_d = '0;
                    if (hfull) begin
                        sreg_d = hdata;
                        htake  = 1'b1;
                    end else if (accept) begin
                        sreg_d = load_data;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (shift_en) begin
                        idx_d = idx_q + IdxW'(1);
                    end
                    hload = accept;
                end
            end
            default: state_d = IDLE;
        endcase

        // The serial bit is computed from next state so it leaves a flop.
        pos   = MSB_FIRST ? (LastIdx - idx_d) : idx_d;
        ser_d = (state_d == SHIFT) ? sreg_d[pos] : IDLE_LEVEL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            idx_q   <= '0;
            ser_q   <= IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            idx_q   <= idx_d;
            ser_q   <= ser_d;
        end
    end

    assign ser_out   = ser_q;
    assign ser_valid = (state_q == SHIFT);
    assign ser_first = ser_valid && (idx_q == '0);
    assign ser_last  = ser_valid && (idx_q == LastIdx);
    assign busy      = ser_valid || hfull;

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out serializer with a valid/ready load handshake, a one-entry holding buffer for gap-free back-to-back words, a bit-rate enable, selectable bit order, and per-bit framing flags. It is the general-purpose successor to the fixed 8-bit serializer in the serial transmit datapath. Upstream logic hands it parallel words, and a line driver or framer downstream consumes the registered serial bit stream.

## Interface
- `WIDTH`, default 8: word width in bits; must be at least 2.
- `MSB_FIRST`, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- `IDLE_LEVEL`, default 0: value driven on `ser_out` when no bit is valid.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `shift_en`  in  1: bit-rate tick; advances the serial stream by one bit.
- `load_data`  in  WIDTH: parallel word to serialize.
- `load_valid`  in  1: `load_data` is offered.
- `load_ready`  out  1: word can be accepted; a transfer happens on an edge with `load_valid` and `load_ready` both high.
- `ser_out`  out  1: registered serial bit.
- `ser_valid`  out  1: `ser_out` carries a data bit.
- `ser_first`  out  1: current bit is the first bit of a word.
- `ser_last`  out  1: current bit is the last bit of a word.
- `busy`  out  1: a word is shifting or the holding buffer is full.

## Operation
- Storage:
  - Shift register `sreg` (WIDTH bits).
  - Bit index `idx` (clog2(WIDTH) bits, counts 0..WIDTH-1).
  - Holding buffer `hbuf` with flag `hfull`.
  - State register: IDLE or SHIFT.
- `load_ready` = !hfull && !rst. `busy` = (state==SHIFT) || hfull.
- IDLE:
  - Outputs: `ser_valid`=0, `ser_first`=0, `ser_last`=0, `ser_out`=IDLE_LEVEL.
  - An accepted word loads directly into `sreg`: idx=0, state goes to SHIFT, and bit 0 of the stream is presented on the same edge. `shift_en` is not required for this.
- SHIFT:
  - Outputs: `ser_valid`=1, `ser_first`=(idx==0), `ser_last`=(idx==WIDTH-1).
  - `ser_out` = `sreg[WIDTH-1-idx]` if MSB_FIRST, else `sreg[idx]`. It is registered and presented as a flop output.
- SHIFT, edge with `shift_en`=1 and idx<WIDTH-1: idx increments and the next bit is presented.
- SHIFT, edge with `shift_en`=1 and idx==WIDTH-1 (word complete):
  - If hfull: move `hbuf` into `sreg`, clear hfull, set idx=0, stay in SHIFT. There is no gap bit.
  - Else, if a word is accepted on this same edge: that word bypasses `hbuf` into `sreg`, idx=0, stay in SHIFT.
  - Else: go to IDLE, `ser_out`=IDLE_LEVEL.
- SHIFT, word accepted on any other edge: it goes into `hbuf` and hfull is set. `load_ready` drops on the next cycle.
- Simultaneous accept and hfull clear is impossible, because `load_ready`=0 whenever hfull=1.
- `shift_en`=0: all state holds, including `ser_out`. A word can still be accepted into `hbuf`.
- `load_data` is sampled only on the accept edge. Later changes have no effect.

## Timing
- Reset (edge with rst=1):
  - State=IDLE, hfull=0, idx=0, sreg=0.
  - `ser_out`=IDLE_LEVEL, `ser_valid`=0, `ser_first`=0, `ser_last`=0, `busy`=0.
  - `load_ready`=0 while rst is high and 1 on the first cycle after.
- Reset mid-word discards both `sreg` and `hbuf`. No remaining bits are emitted, and outputs are idle from the next cycle. Reset has priority over every other event.
- Latency: accept edge to first bit on `ser_out` is 0 edges; the bit is visible immediately after the accept edge.
- With `shift_en` tied high:
  - Each bit lasts exactly 1 cycle and a word occupies WIDTH cycles.
  - Continuous streaming is sustained if upstream refills `hbuf` at least once per WIDTH cycles.
- With `shift_en` pulsing every N cycles, each bit is held until its consuming `shift_en` edge.

## Structure
- Package `piso_pkg` holds:
  - `piso_state_t` enum {IDLE, SHIFT}.
  - The function computing the index width, clog2(WIDTH) with a minimum of 1.
- One natural sub-module, `piso_hold_buf`:
  - One-entry register with full flag, load, and take ports.
  - Instantiated once; the top holds the FSM, `sreg` and `idx`.
- No other hierarchy.

## Test plan
- Reset release → `ser_out`=0, `ser_valid`=0, `busy`=0, `load_ready`=1 on the first cycle after rst drops; outputs stay idle with no load.
- Load 0xA5 with `shift_en`=1 constantly (MSB_FIRST) → `ser_out` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles. `ser_first` is high on the 1st only and `ser_last` on the 8th only. The line returns to 0 with `ser_valid`=0 on the 9th.
- Load 0x3C, then 0xC3 two cycles later → `load_ready` low until the transfer, and 16 contiguous valid bits 0011110011000011 with no gap bit.
- Load 0x81 with `shift_en` high every 4th cycle → each bit is held for 4 cycles. A load offered during the word goes to `hbuf` and waits; it is not corrupted.
- LSB_FIRST instance (MSB_FIRST=0), IDLE_LEVEL=1, load 0x01 → bits 1,0,0,0,0,0,0,0, then `ser_out` returns to 1.
- Assert rst after 3 bits of 0xFF, with 0x55 in `hbuf` → next cycle is idle with `busy`=0. After release, a new 0x0F load emits only 00001111.
